// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types for the instruction fetch unit and its buffer
//
// Purpose: fetch FSM state encoding and the instruction buffer entry layout.
// Ports:   none (package).

package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        WAIT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer holding {pc, data} entries
//
// Purpose: power-of-two deep FIFO between the fetch FSM and decode.
// Ports:
//   clk, rst     - rising-edge clock, synchronous active-high reset
//   push, push_entry - write request and entry (ignored when full)
//   pop          - read request (ignored when empty)
//   flush        - discard all entries; wins over push and pop
//   full, empty  - occupancy flags from the current count
//   head         - oldest entry, combinational

import fetch_pkg::*;

module fetch_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - sequential instruction fetcher with buffer
//
// Purpose: walks pc through the instruction cache one word at a time and
//          queues {pc, word} for decode; supports redirects.
// Ports:
//   HCLK, HRESET             - rising-edge clock, synchronous active-high reset
//   fetch_enable             - allows fetching
//   cpu_addr / cpu_data / cpu_ready - cache request address, returned word, hit
//   redirect_valid / redirect_pc    - control-flow redirect and target
//   instr_valid / instr_ready       - decode handshake on the buffer head
//   instr_data / instr_pc           - head instruction word and its address

import fetch_pkg::*;

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        fetch_enable,
    output logic [31:0] cpu_addr,
    input  logic [31:0] cpu_data,
    input  logic        cpu_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);

    fetch_state_t cur_state;
    fetch_state_t nxt_state;
    logic [31:0]  pc;
    logic         push;
    logic         pop;
    logic         buf_full;
    logic         buf_empty;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    assign cpu_addr    = pc;
    assign instr_valid = !buf_empty;
    assign instr_data  = head.data;
    assign instr_pc    = head.pc;
    assign pop         = instr_valid && instr_ready && !redirect_valid;

    assign push_entry.pc   = pc;
    assign push_entry.data = cpu_data;

    // BLANK exists because the cache's ready is registered: the cycle after
    // an address change still shows the hit for the previous address.
    always_comb begin
        nxt_state = cur_state;
        push      = 1'b0;
        case (cur_state)
            IDLE: begin
                if (fetch_enable) begin
                    nxt_state = BLANK;
                end
            end
            BLANK: begin
                nxt_state = fetch_enable ? WAIT : IDLE;
            end
            WAIT: begin
                if (!fetch_enable) begin
                    nxt_state = IDLE;
                end else if (cpu_ready && !buf_full) begin
                    push      = 1'b1;
                    nxt_state = BLANK;
                end
            end
            default: nxt_state = IDLE;
        endcase
        // A redirect discards whatever the cache returned this cycle.
        if (redirect_valid) begin
            push      = 1'b0;
            nxt_state = fetch_enable ? BLANK : IDLE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cur_state <= IDLE;
            pc        <= RESET_PC;
        end else begin
            cur_state <= nxt_state;
            if (redirect_valid) begin
                pc <= redirect_pc & 32'hFFFF_FFFC;
            end else if (push) begin
                pc <= pc + PC_STEP;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk        (HCLK),
        .rst        (HRESET),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .full       (buf_full),
        .empty      (buf_empty),
        .head       (head)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit

module tb_instruction_fetch_unit;

    logic        HCLK;
    logic        HRESET;
    logic        fetch_enable;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        cpu_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    int tests;
    int fails;

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0100),
        .FIFO_DEPTH (4)
    ) dut (
        .HCLK           (HCLK),
        .HRESET         (HRESET),
        .fetch_enable   (fetch_enable),
        .cpu_addr       (cpu_addr),
        .cpu_data       (cpu_data),
        .cpu_ready      (cpu_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Cache model: the word stored at an address is the address xor DEAD_0000.
    assign cpu_data = cpu_addr ^ 32'hDEAD_0000;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        HRESET         = 1'b1;
        fetch_enable   = 1'b0;
        cpu_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;

        tick();
        check("rst_addr",  cpu_addr,           32'h0000_0100);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_data",  instr_data,         32'h0);
        check("rst_pc",    instr_pc,           32'h0);

        HRESET       = 1'b0;
        fetch_enable = 1'b1;
        cpu_ready    = 1'b1;
        tick();                                  // IDLE -> BLANK
        check("idle_blank_valid", {31'b0, instr_valid}, 32'h0);
        tick();                                  // BLANK -> WAIT, ready ignored
        check("blank_no_push", {31'b0, instr_valid}, 32'h0);
        tick();                                  // push 0x100
        check("push0_valid", {31'b0, instr_valid}, 32'h1);
        check("push0_pc",    instr_pc,   32'h0000_0100);
        check("push0_data",  instr_data, 32'hDEAD_0100);
        check("push0_addr",  cpu_addr,   32'h0000_0104);
        tick();                                  // BLANK with ready high
        check("blank_hold_addr", cpu_addr, 32'h0000_0104);
        tick();                                  // push 0x104
        check("push1_addr", cpu_addr, 32'h0000_0108);
        tick();
        check("push1_blank_addr", cpu_addr, 32'h0000_0108);
        tick();                                  // push 0x108
        check("push2_addr", cpu_addr, 32'h0000_010C);
        tick();
        tick();                                  // push 0x10C, buffer full
        check("push3_addr", cpu_addr, 32'h0000_0110);
        tick();                                  // BLANK -> WAIT
        tick();                                  // full: drop
        check("full_hold1", cpu_addr, 32'h0000_0110);
        tick();
        check("full_hold2", cpu_addr, 32'h0000_0110);
        check("full_head",  instr_pc, 32'h0000_0100);

        instr_ready = 1'b1;
        tick();                                  // pop while full: no push
        check("pop_full_nopush", cpu_addr, 32'h0000_0110);
        check("pop_head1",       instr_pc, 32'h0000_0104);
        instr_ready = 1'b0;
        tick();                                  // resume: push 0x110
        check("resume_addr", cpu_addr, 32'h0000_0114);

        fetch_enable = 1'b0;
        instr_ready  = 1'b1;
        check("drain0_pc",   instr_pc,   32'h0000_0104);
        check("drain0_data", instr_data, 32'hDEAD_0104);
        tick();
        check("drain1_pc", instr_pc, 32'h0000_0108);
        tick();
        check("drain2_pc", instr_pc, 32'h0000_010C);
        tick();
        check("drain3_pc",   instr_pc,   32'h0000_0110);
        check("drain3_data", instr_data, 32'hDEAD_0110);
        tick();
        check("drain_empty",   {31'b0, instr_valid}, 32'h0);
        check("disabled_addr", cpu_addr, 32'h0000_0114);
        tick();
        check("idle_hold_addr", cpu_addr, 32'h0000_0114);

        fetch_enable = 1'b1;
        instr_ready  = 1'b0;
        tick();                                  // BLANK
        tick();                                  // WAIT
        tick();                                  // push 0x114
        check("refetch_pc", instr_pc, 32'h0000_0114);
        tick();                                  // WAIT, ready high
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2003;
        tick();                                  // redirect wins over push
        check("redir_valid", {31'b0, instr_valid}, 32'h0);
        check("redir_addr",  cpu_addr, 32'h0000_2000);
        redirect_valid = 1'b0;
        tick();                                  // WAIT
        check("redir_blank_valid", {31'b0, instr_valid}, 32'h0);
        tick();                                  // push 0x2000
        check("redir_push_pc",   instr_pc,   32'h0000_2000);
        check("redir_push_data", instr_data, 32'hDEAD_2000);
        check("redir_push_addr", cpu_addr,   32'h0000_2004);

        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        check("wrap_redir_addr", cpu_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        tick();                                  // WAIT
        tick();                                  // push 0xFFFFFFFC
        check("wrap_addr", cpu_addr,   32'h0000_0000);
        check("wrap_pc",   instr_pc,   32'hFFFF_FFFC);
        check("wrap_data", instr_data, 32'h2152_FFFC);

        tick();                                  // WAIT, ready high
        HRESET = 1'b1;
        tick();
        check("midrst_addr",  cpu_addr, 32'h0000_0100);
        check("midrst_valid", {31'b0, instr_valid}, 32'h0);
        check("midrst_pc",    instr_pc, 32'h0);

        HRESET      = 1'b0;
        instr_ready = 1'b1;
        tick();                                  // BLANK
        tick();                                  // WAIT
        tick();                                  // push 0x100
        check("post_rst_pc",    instr_pc, 32'h0000_0100);
        check("post_rst_valid", {31'b0, instr_valid}, 32'h1);
        tick();                                  // popped
        check("post_rst_pop", {31'b0, instr_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
